// File: rtl/youssefland_click_decoder_pkg.sv
// ============================================================================
// Module      : youssefland_click_decoder_pkg
// Description : Shared state encodings and the ms-to-cycles conversion helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package youssefland_click_decoder_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    // Divide before multiplying so large clock rates do not overflow 32 bits.
    function automatic int ms_to_cycles(input int clk_frequency, input int window_ms);
        return clk_frequency / 1000 * window_ms;
    endfunction

endpackage

`default_nettype wire

// File: rtl/youssefland_click_decoder_if.sv
// ============================================================================
// Module      : youssefland_click_decoder_if
// Description : Click-count result handshake toward the application FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface youssefland_click_decoder_if #(
    parameter int CNT_W = 3
);
    logic             click_valid;
    logic [CNT_W-1:0] click_count;
    logic             click_ready;

    modport master (output click_valid, output click_count, input click_ready);
    modport slave  (input click_valid, input click_count, output click_ready);
endinterface

`default_nettype wire

// File: rtl/youssefland_window_timer.sv
// ============================================================================
// Module      : youssefland_window_timer
// Description : Restartable up-counter flagging the last cycle of the window.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module youssefland_window_timer #(
    parameter int WINDOW_CYCLES = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      terminal
);
    localparam int TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TMR_W-1:0] C_LAST = TMR_W'(WINDOW_CYCLES - 1);

    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_timer <= '0;
        end else if (enable) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign terminal = (r_timer == C_LAST);

endmodule

`default_nettype wire

// File: rtl/youssefland_click_decoder.sv
// ============================================================================
// Module      : youssefland_click_decoder
// Description : Groups press pulses separated by less than a quiet window into
//               one burst and reports the saturated click count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module youssefland_click_decoder
    import youssefland_click_decoder_pkg::*;
#(
    parameter int CLK_FREQUENCY = 10_000_000,
    parameter int WINDOW_MS     = 250,
    parameter int MAX_CLICKS    = 7
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic press,
    output logic      dropped,
    output logic      busy,
    youssefland_click_decoder_if.master click
);
    localparam int WINDOW_CYCLES = ms_to_cycles(CLK_FREQUENCY, WINDOW_MS);
    localparam int CNT_W         = $clog2(MAX_CLICKS + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    generate
        if (WINDOW_CYCLES < 2 || MAX_CLICKS < 1) begin : g_param_check
            $error("youssefland_click_decoder: WINDOW_CYCLES must be >= 2 and MAX_CLICKS >= 1");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             w_expired;
    logic             w_tmr_clear;
    logic             w_tmr_enable;

    // Timer sits at zero outside GATHER so each burst starts from a clean window.
    assign w_tmr_enable = (r_state == S_GATHER);
    assign w_tmr_clear  = (r_state != S_GATHER) || press || w_expired;

    youssefland_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_window_timer (
        .clk      (clk),
        .rst      (reset),
        .clear    (w_tmr_clear),
        .enable   (w_tmr_enable),
        .terminal (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_count           <= '0;
            click.click_valid <= 1'b0;
            click.click_count <= '0;
            dropped           <= 1'b0;
            busy              <= 1'b0;
        end else begin
            dropped <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (press) begin
                        r_state <= S_GATHER;
                        r_count <= C_ONE;
                        busy    <= 1'b1;
                    end
                end
                S_GATHER: begin
                    // A press on the expiry cycle extends the burst.
                    if (press) begin
                        if (r_count != C_MAX) begin
                            r_count <= r_count + 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state           <= S_EMIT;
                        click.click_valid <= 1'b1;
                        click.click_count <= r_count;
                    end
                end
                S_EMIT: begin
                    if (click.click_ready) begin
                        click.click_valid <= 1'b0;
                        if (press) begin
                            r_state <= S_GATHER;
                            r_count <= C_ONE;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else if (press) begin
                        dropped <= 1'b1;
                    end
                end
                default: begin
                    r_state           <= S_IDLE;
                    click.click_valid <= 1'b0;
                    busy              <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_youssefland_click_decoder.sv
// ============================================================================
// Module      : tb_youssefland_click_decoder
// Description : Scoreboard bench for the click decoder (8-cycle window, max 3).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_youssefland_click_decoder;

    typedef struct {
        int cnt;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic press = 1'b0;
    logic ready = 1'b1;
    logic dropped;
    logic busy;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;

    exp_t exp_q[$];
    int   drop_q[$];

    youssefland_click_decoder_if #(.CNT_W(2)) click_if ();
    assign click_if.click_ready = ready;

    youssefland_click_decoder #(
        .CLK_FREQUENCY (8000),
        .WINDOW_MS     (1),
        .MAX_CLICKS    (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .press   (press),
        .dropped (dropped),
        .busy    (busy),
        .click   (click_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press high for exactly the current cycle.
    task automatic press_now();
        press = 1'b1;
        @(posedge clk);
        #1;
        press = 1'b0;
    endtask

    // Monitor: compares each result and drop pulse against the scoreboard.
    initial begin : monitor
        logic prev_valid;
        logic prev_ready;
        int   cur_count;
        exp_t e;
        int   d;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        cur_count  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (click_if.click_valid) begin
                    if (prev_valid && prev_ready) begin
                        chk("valid_after_accept", 1, 0);
                    end else if (!prev_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("result_count", int'(click_if.click_count), e.cnt);
                            chk("result_cycle", cyc, e.cyc);
                            cur_count = e.cnt;
                        end
                    end else begin
                        chk("count_stable", int'(click_if.click_count), cur_count);
                    end
                end
                if (dropped) begin
                    if (drop_q.size() == 0) begin
                        chk("unexpected_drop", 1, 0);
                    end else begin
                        d = drop_q.pop_front();
                        chk("drop_cycle", cyc, d);
                    end
                end
                prev_valid = click_if.click_valid;
                prev_ready = ready;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid",   int'(click_if.click_valid), 0);
        chk("reset_count",   int'(click_if.click_count), 0);
        chk("reset_dropped", int'(dropped), 0);
        chk("reset_busy",    int'(busy), 0);
        idle(1);
        reset = 1'b0;
        idle(2);

        // Single press, consumer ready: one-cycle result at t0+9.
        t0 = cyc;
        exp_q.push_back('{1, t0 + 9});
        press_now();
        idle(8);
        @(negedge clk);
        chk("single_busy_in_emit", int'(busy), 1);
        idle(1);
        @(negedge clk);
        chk("single_valid_cleared", int'(click_if.click_valid), 0);
        chk("single_busy_cleared",  int'(busy), 0);
        idle(3);

        // Presses at t0, t0+3, t0+10.
        t0 = cyc;
        exp_q.push_back('{3, t0 + 19});
        press_now();
        idle(2);
        press_now();
        idle(6);
        press_now();
        idle(12);

        // Five presses two cycles apart saturate at 3.
        t0 = cyc;
        exp_q.push_back('{3, t0 + 17});
        repeat (5) begin
            press_now();
            idle(1);
        end
        idle(12);

        // Stalled consumer: press at valid+4 is dropped at valid+5.
        ready = 1'b0;
        t0 = cyc;
        exp_q.push_back('{1, t0 + 9});
        drop_q.push_back(t0 + 14);
        press_now();
        idle(12);
        press_now();
        idle(15);
        ready = 1'b1;
        idle(3);

        // Press on the accept cycle restarts a burst without a drop.
        ready = 1'b0;
        t0 = cyc;
        exp_q.push_back('{1, t0 + 9});
        press_now();
        idle(10);
        ready = 1'b1;
        exp_q.push_back('{1, t0 + 20});
        press_now();
        idle(12);

        // Reset two cycles into GATHER discards the burst.
        press_now();
        idle(1);
        reset = 1'b1;
        idle(1);
        @(negedge clk);
        chk("midreset_valid",   int'(click_if.click_valid), 0);
        chk("midreset_count",   int'(click_if.click_count), 0);
        chk("midreset_dropped", int'(dropped), 0);
        chk("midreset_busy",    int'(busy), 0);
        idle(1);
        reset = 1'b0;
        idle(15);

        // Press exactly on the expiry cycle keeps gathering.
        t0 = cyc;
        exp_q.push_back('{2, t0 + 17});
        press_now();
        idle(7);
        press_now();
        @(negedge clk);
        chk("expiry_press_busy",  int'(busy), 1);
        chk("expiry_press_valid", int'(click_if.click_valid), 0);
        idle(12);

        chk("pending_results", exp_q.size(), 0);
        chk("pending_drops",   drop_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
